flap_input_conditioner: RTL
===========================

# flap_input_conditioner

Parametrised multi-channel successor to the single-channel flap-button register. It conditions N raw push-button inputs for the game logic: two-flop synchronisation, counter-based debounce, a one-cycle `press` pulse per press, and an optional per-channel auto-repeat mode that keeps issuing flap pulses while a button is held. It sits between the board key inputs and the game state machines, which consume `press` as the flap command.

## Interface

- `N`, 4, number of independent button channels (≥1)
- `DB_CYCLES`, 4, consecutive stable synchronised cycles required to accept a level change (≥2)
- `HOLD_CYCLES`, 16, cycles from the initial press pulse to the first auto-repeat pulse (≥2)
- `REPEAT_CYCLES`, 8, cycles between successive auto-repeat pulses (≥2)
- Counter width derived as `$clog2(max(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1)`; not user-set

- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-low reset; `reset`=0 at a rising edge clears all state
- `button`  in  N  raw asynchronous button levels, 1 = pressed
- `repeat_en`  in  N  per-channel auto-repeat enable, synchronous to `clk`
- `level`  out  N  debounced button level
- `press`  out  N  one-cycle flap pulse: initial press and each auto-repeat
- `held`  out  N  1 while the channel is in REPEAT state

## Operation

- All outputs registered. During and after reset: `level`=0, `press`=0, `held`=0; sync flops, counters 0; FSM in IDLE.
- Channels fully independent; no shared state.
- Sync: `s1<=button[i]`, `s2<=s1`.
- Debounce: if `s2==level`, `db_cnt<=0`. Otherwise `db_cnt` increments; on the edge where `db_cnt==DB_CYCLES-1` and `s2!=level`, `level<=s2`, `db_cnt<=0`. Any return of `s2` to `level` before then clears the count.
- Rise event = `level` 0→1 at an edge; fall event = 1→0.
- FSM per channel:
  - IDLE: rise → `press`=1 next cycle, go HOLD, `hold_cnt<=0`.
  - HOLD: fall → IDLE. Else `hold_cnt` increments, saturating at `HOLD_CYCLES-1`. At `hold_cnt==HOLD_CYCLES-1` with `repeat_en`=1 → `press`=1, go REPEAT, `rep_cnt<=0`.
  - REPEAT (`held`=1): fall → IDLE. `repeat_en`=0 → HOLD, `hold_cnt<=0`, no pulse. Else `rep_cnt` increments; at `rep_cnt==REPEAT_CYCLES-1` → `press`=1, `rep_cnt<=0`.
- Release never produces `press`.
- Fall has priority over a coincident repeat pulse: no pulse, go IDLE.
- With `repeat_en`=0, `hold_cnt` sits saturated. Raising `repeat_en` then fires a repeat at the next edge.

## Timing

- Button rises before edge E0 and stays high: `s1`=1 after E0, `s2` after E1, `level`=1 and `press`=1 after edge E(DB_CYCLES+1). `press` clears after E(DB_CYCLES+2).
- Release latency is the same: `level`=0 after E(DB_CYCLES+1) from the release.
- Let Er be the rise edge. With `repeat_en` held at 1:
  - repeat pulses after Er+HOLD_CYCLES, Er+HOLD_CYCLES+REPEAT_CYCLES, and so on
  - `held`=1 from Er+HOLD_CYCLES.
- Max `press` duty in REPEAT: 1 in REPEAT_CYCLES.
- Reset mid-operation clears everything within that edge; no pulse is emitted on reset.
- If the button is still held after reset release, the channel re-debounces and issues a fresh `press` DB_CYCLES+1 edges later.

## Test plan

Defaults throughout: N=4, DB=4, HOLD=16, REPEAT=8.

- Reset: hold `reset`=0 for 2 cycles with `button`=4'hF → `level`, `press`, `held` all 0. Release reset → ch0–3 `level`=1 and one `press` pulse after 5th edge.
- Glitch reject: ch0 `button`=1 for 3 cycles, then 0 → `level[0]`, `press[0]` never assert. 1,1,0,1,1,1,1 → `level` rises only after the final 4-cycle run.
- Single tap, `repeat_en`=0: hold ch1 for 40 cycles → exactly one `press[1]`, `held[1]`=0 throughout, no pulse on release.
- Auto-repeat, `repeat_en[2]`=1, hold 50 cycles after the rise: `press[2]` at Er, Er+16, Er+24, Er+32, Er+40, Er+48. `held[2]`=1 from Er+16 until the fall.
- Simultaneous events: ch3 fall coinciding with a repeat edge → no pulse, IDLE. Toggle `repeat_en[2]` 1→0→1 in REPEAT → returns to HOLD, next repeat 16 cycles later.
- Channel independence: staggered presses on all 4 channels → each channel's pulses match its single-channel expectation exactly.

Source files
------------

// File: rtl/flap_input_conditioner.sv
// Per-channel push-button conditioner: two-flop sync, counter debounce, one-cycle press
// pulse on each accepted press, and optional auto-repeat while the button stays held.
module flap_input_conditioner #(
  parameter int unsigned N             = 4,
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] button,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] held
);

  localparam int unsigned MaxDbHold = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
  localparam int unsigned MaxCycles = (MaxDbHold > REPEAT_CYCLES) ? MaxDbHold : REPEAT_CYCLES;
  localparam int unsigned CW        = $clog2(MaxCycles + 1);

  localparam logic [CW-1:0] DbLast   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RepLast  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          press_q, held_q;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] hold_cnt_q, rep_cnt_q;
    logic          rise, fall;
    state_e        state_q;

    // The FSM reacts to the level change in the same edge it is accepted, so press
    // appears together with the new level.
    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (s2_q != level_q) begin
        if (db_cnt_q == DbLast) begin
          level_d = s2_q;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        s1_q       <= 1'b0;
        s2_q       <= 1'b0;
        level_q    <= 1'b0;
        db_cnt_q   <= '0;
        press_q    <= 1'b0;
        held_q     <= 1'b0;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        state_q    <= StIdle;
      end else begin
        s1_q     <= button[i];
        s2_q     <= s1_q;
        level_q  <= level_d;
        db_cnt_q <= db_cnt_d;
        press_q  <= 1'b0;
        case (state_q)
          StIdle: begin
            held_q <= 1'b0;
            if (rise) begin
              press_q    <= 1'b1;
              hold_cnt_q <= '0;
              state_q    <= StHold;
            end
          end
          StHold: begin
            if (fall) begin
              held_q  <= 1'b0;
              state_q <= StIdle;
            end else if (hold_cnt_q == HoldLast && repeat_en[i]) begin
              press_q   <= 1'b1;
              held_q    <= 1'b1;
              rep_cnt_q <= '0;
              state_q   <= StRepeat;
            end else if (hold_cnt_q != HoldLast) begin
              hold_cnt_q <= hold_cnt_q + CW'(1);
            end
          end
          StRepeat: begin
            // A release wins over a repeat pulse due on the same edge.
            if (fall) begin
              held_q  <= 1'b0;
              state_q <= StIdle;
            end else if (!repeat_en[i]) begin
              held_q     <= 1'b0;
              hold_cnt_q <= '0;
              state_q    <= StHold;
            end else if (rep_cnt_q == RepLast) begin
              press_q   <= 1'b1;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + CW'(1);
            end
          end
          default: begin
            held_q  <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end

    assign level[i] = level_q;
    assign press[i] = press_q;
    assign held[i]  = held_q;
  end

endmodule
